vshift_seq: RTL and testbench
=============================

VSHIFT_SEQ -- requirements
Module: vshift_seq

Interface
REQ-001 The module SHALL have these parameters: DATA_WIDTH, default 32, element width in bits; MAX_VL, default 8, maximum elements per instruction; VL_W, default 4, width of vl_i and of the index ports.
REQ-002 The module SHALL have these ports, one per line as name, direction, width, meaning:
- clk_i  in  1  single clock; all state updates on its rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- start_i  in  1  instruction request.
- ready_o  out  1  idle; request accepted when start_i & ready_o.
- op_i  in  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 treated as SLL.
- vl_i  in  VL_W  element count.
- scalar_sel_i  in  1  1 = shift amount from scalar_i, 0 = per-element from rd_b_i.
- scalar_i  in  DATA_WIDTH  scalar shift amount.
- kill_i  in  1  abort current instruction.
- rd_en_o  out  1  operand read strobe.
- rd_idx_o  out  VL_W  element index being read.
- rd_a_i  in  DATA_WIDTH  element data; valid the cycle after rd_en_o.
- rd_b_i  in  DATA_WIDTH  element shift amount; valid the cycle after rd_en_o.
- sh_a_o  out  DATA_WIDTH  operand to the shared shifter.
- sh_amt_o  out  DATA_WIDTH  shift amount to the shared shifter.
- sh_dir_o  out  1  1 = sh_amt_o is signed; negative means shift right.
- sh_tc_o  out  1  1 = sh_a_o is signed (arithmetic right shift).
- sh_result_i  in  DATA_WIDTH  shifter result, combinational from the sh_* outputs.
- wr_en_o  out  1  result write strobe.
- wr_idx_o  out  VL_W  result element index.
- wr_data_o  out  DATA_WIDTH  result data.
- done_o  out  1  one-cycle completion pulse.
- mask_i  in  MAX_VL  element enable mask; this port exists only with VSHIFT_MASK_EN.

Function
REQ-003 The module SHALL capture op_i, vl_i, scalar_sel_i, scalar_i and, when present, mask_i on acceptance; later input changes SHALL have no effect on the running instruction.
REQ-004 If vl_i exceeds MAX_VL, the captured element count SHALL be MAX_VL.
REQ-005 The FSM SHALL have four states: IDLE, which goes to RUN on acceptance with vl>0 and to DONE when vl=0; RUN; DRAIN; and DONE, which goes to IDLE.
REQ-006 ready_o SHALL be 1 only in IDLE; start_i SHALL be ignored in every other state.
REQ-007 In RUN, rd_en_o SHALL be 1 every cycle with rd_idx_o = 0,1,...,vl-1; with acceptance at cycle 0, reads occur in cycles 1..vl, then the FSM goes to DRAIN.
REQ-008 Stage 1 SHALL latch rd_a_i and rd_b_i, together with their index, in the cycle after each rd_en_o.
REQ-009 The sh_* outputs SHALL be driven combinationally from stage 1.
REQ-010 The shift magnitude SHALL be the low log2(DATA_WIDTH) bits of the selected amount; higher bits are ignored.
REQ-011 For SLL, sh_amt_o = magnitude, sh_dir_o=0, sh_tc_o=0.
REQ-012 For SRL, sh_amt_o = two's complement negation of magnitude, sh_dir_o=1, sh_tc_o=0.
REQ-013 For SRA, sh_amt_o = two's complement negation of magnitude, sh_dir_o=1, sh_tc_o=1.
REQ-014 Stage 2 SHALL register sh_result_i and the index; wr_en_o for element k SHALL be asserted in cycle k+3, one element per cycle with no bubbles.
REQ-015 done_o SHALL pulse in the cycle of the last write (cycle vl+2, DRAIN to DONE); ready_o SHALL return to 1 in the following cycle.
REQ-016 For vl=0, there SHALL be no reads and no writes, done_o SHALL pulse in cycle 1, and ready_o SHALL be 1 in cycle 2.
REQ-017 kill_i high in RUN, DRAIN or DONE SHALL force IDLE on the next edge, clear all pipeline valids, suppress done_o and suppress all writes from that edge on.
REQ-018 A write asserted in the same cycle that kill_i is sampled SHALL still complete.
REQ-019 kill_i in IDLE SHALL have no effect.
REQ-020 A start_i applied together with kill_i SHALL be ignored.
REQ-021 rd_idx_o, wr_idx_o, wr_data_o and sh_* SHALL hold their last value while the corresponding strobe is low.

Reset
REQ-022 While rst_i is high, the module SHALL be in IDLE with: ready_o=1; rd_en_o, wr_en_o and done_o = 0; rd_idx_o, wr_idx_o and wr_data_o = 0; stage valids = 0; captured fields = 0.
REQ-023 Reset asserted mid-instruction SHALL abort it immediately, with no further writes and no done_o.
REQ-024 After rst_i deasserts, the first acceptance SHALL be possible at the first edge.

Configuration
REQ-025 With macro VSHIFT_MASK_EN defined, port mask_i SHALL exist.
REQ-026 With VSHIFT_MASK_EN defined, element k with captured mask bit 0 SHALL still be read and timed normally, but wr_en_o SHALL stay 0 in its write cycle.
REQ-027 With VSHIFT_MASK_EN defined, done_o timing SHALL be unchanged even if all bits are 0.
REQ-028 Without VSHIFT_MASK_EN, mask_i SHALL be absent and every element SHALL be written.

Verification
REQ-029 Scalar SLL: vl=4, scalar=3, scalar_sel=1, elements 1,2,3,4 -> writes 8,16,24,32 at cycles 3..6, done_o at cycle 6, ready_o=1 at cycle 7.
REQ-030 SRA per-element: a=0x80000000, b=0x24 -> write 0xF8000000 (amount masked to 4); with SRL -> 0x08000000.
REQ-031 vl=0 -> no rd_en_o or wr_en_o, done_o at cycle 1; vl=12 with MAX_VL=8 -> exactly 8 writes, indices 0..7.
REQ-032 kill_i at cycle 4 of a vl=8 run -> writes for elements 0 and 1 only, no done_o, ready_o=1 at cycle 5, start_i at cycle 5 accepted.
REQ-033 With VSHIFT_MASK_EN, mask=0b0101 and vl=4 -> wr_en_o only for indices 0 and 2, done_o at cycle 6; rst_i pulse at cycle 3 -> no writes, outputs at reset values.

Source files
------------

// File: rtl/vshift_seq.sv
// ============================================================================
// Module   : vshift_seq
// Function : Sequential vector shift sequencer (SLL/SRL/SRA) driving a shared
//            shifter; optional per-element write mask with VSHIFT_MASK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vshift_seq #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_VL     = 8,
  parameter int VL_W       = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  output logic                  ready_o,
  input  logic [1:0]            op_i,
  input  logic [VL_W-1:0]       vl_i,
  input  logic                  scalar_sel_i,
  input  logic [DATA_WIDTH-1:0] scalar_i,
  input  logic                  kill_i,
  output logic                  rd_en_o,
  output logic [VL_W-1:0]       rd_idx_o,
  input  logic [DATA_WIDTH-1:0] rd_a_i,
  input  logic [DATA_WIDTH-1:0] rd_b_i,
  output logic [DATA_WIDTH-1:0] sh_a_o,
  output logic [DATA_WIDTH-1:0] sh_amt_o,
  output logic                  sh_dir_o,
  output logic                  sh_tc_o,
  input  logic [DATA_WIDTH-1:0] sh_result_i,
  output logic                  wr_en_o,
  output logic [VL_W-1:0]       wr_idx_o,
  output logic [DATA_WIDTH-1:0] wr_data_o,
  output logic                  done_o
`ifdef VSHIFT_MASK_EN
  ,
  input  logic [MAX_VL-1:0]     mask_i
`endif
);

  localparam int              SHW      = $clog2(DATA_WIDTH);
  localparam logic [VL_W-1:0] MAX_VL_C = VL_W'(MAX_VL);
  localparam logic [VL_W-1:0] ONE_VL   = VL_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [1:0]            op_q, op_d;
  logic [VL_W-1:0]       vl_q, vl_d;
  logic                  sel_q, sel_d;
  logic [SHW-1:0]        scalar_q, scalar_d;
  logic [VL_W-1:0]       rd_idx_q, rd_idx_d;

  logic                  s1_valid_q, s1_valid_d;
  logic [DATA_WIDTH-1:0] s1_a_q, s1_a_d;
  logic [SHW-1:0]        s1_mag_q, s1_mag_d;
  logic [1:0]            s1_op_q, s1_op_d;
  logic [VL_W-1:0]       s1_idx_q, s1_idx_d;
  logic                  s1_en_q, s1_en_d;

  logic                  wr_en_q, wr_en_d;
  logic [VL_W-1:0]       wr_idx_q, wr_idx_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;

  logic                  accept;
  logic [VL_W-1:0]       vl_sat;
  logic                  last_rd;
  logic                  s1_load;
  logic                  elem_en;
  logic [DATA_WIDTH-1:0] mag_ext;

  // Only the low SHW bits of any shift amount are meaningful.
  logic unused_bits;
  assign unused_bits = ^{scalar_i[DATA_WIDTH-1:SHW], rd_b_i[DATA_WIDTH-1:SHW]};

`ifdef VSHIFT_MASK_EN
  localparam logic [MAX_VL-1:0] ONE_MASK = MAX_VL'(1);
  logic [MAX_VL-1:0] mask_q, mask_d;

  always_comb begin
    mask_d  = accept ? mask_i : mask_q;
    elem_en = |(mask_q & (ONE_MASK << rd_idx_q));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) mask_q <= '0;
    else       mask_q <= mask_d;
  end
`else
  assign elem_en = 1'b1;
`endif

  // Control: FSM, instruction capture and read sequencing.
  always_comb begin
    accept   = (state_q == S_IDLE) && start_i && !kill_i;
    vl_sat   = (vl_i > MAX_VL_C) ? MAX_VL_C : vl_i;
    last_rd  = (rd_idx_q == (vl_q - ONE_VL));
    state_d  = state_q;
    op_d     = op_q;
    vl_d     = vl_q;
    sel_d    = sel_q;
    scalar_d = scalar_q;
    rd_idx_d = rd_idx_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d     = op_i;
          vl_d     = vl_sat;
          sel_d    = scalar_sel_i;
          scalar_d = scalar_i[SHW-1:0];
          if (vl_sat == '0) begin
            state_d = S_DONE;
          end else begin
            state_d  = S_RUN;
            rd_idx_d = '0;
          end
        end
      end
      S_RUN: begin
        if (kill_i)       state_d = S_IDLE;
        else if (last_rd) state_d = S_DRAIN;
        else              rd_idx_d = rd_idx_q + ONE_VL;
      end
      S_DRAIN: state_d = kill_i ? S_IDLE : S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Stage 1 captures the operand pair returned for the read issued last cycle.
  always_comb begin
    s1_load    = (state_q == S_RUN) && !kill_i;
    s1_valid_d = s1_load;
    s1_a_d     = s1_a_q;
    s1_mag_d   = s1_mag_q;
    s1_op_d    = s1_op_q;
    s1_idx_d   = s1_idx_q;
    s1_en_d    = s1_en_q;
    if (s1_load) begin
      s1_a_d   = rd_a_i;
      s1_mag_d = sel_q ? scalar_q : rd_b_i[SHW-1:0];
      s1_op_d  = op_q;
      s1_idx_d = rd_idx_q;
      s1_en_d  = elem_en;
    end
  end

  // Right shifts are expressed as a negative signed amount to the shared unit.
  always_comb begin
    mag_ext  = {{(DATA_WIDTH-SHW){1'b0}}, s1_mag_q};
    sh_a_o   = s1_a_q;
    sh_amt_o = mag_ext;
    sh_dir_o = 1'b0;
    sh_tc_o  = 1'b0;
    unique case (s1_op_q)
      2'b01: begin
        sh_amt_o = '0 - mag_ext;
        sh_dir_o = 1'b1;
      end
      2'b10: begin
        sh_amt_o = '0 - mag_ext;
        sh_dir_o = 1'b1;
        sh_tc_o  = 1'b1;
      end
      default: ;
    endcase
  end

  // Stage 2 only updates on an actual write so outputs hold between strobes.
  always_comb begin
    wr_en_d   = s1_valid_q && s1_en_q && !kill_i;
    wr_idx_d  = wr_en_d ? s1_idx_q    : wr_idx_q;
    wr_data_d = wr_en_d ? sh_result_i : wr_data_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      vl_q       <= '0;
      sel_q      <= 1'b0;
      scalar_q   <= '0;
      rd_idx_q   <= '0;
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_mag_q   <= '0;
      s1_op_q    <= '0;
      s1_idx_q   <= '0;
      s1_en_q    <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_idx_q   <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      vl_q       <= vl_d;
      sel_q      <= sel_d;
      scalar_q   <= scalar_d;
      rd_idx_q   <= rd_idx_d;
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_mag_q   <= s1_mag_d;
      s1_op_q    <= s1_op_d;
      s1_idx_q   <= s1_idx_d;
      s1_en_q    <= s1_en_d;
      wr_en_q    <= wr_en_d;
      wr_idx_q   <= wr_idx_d;
      wr_data_q  <= wr_data_d;
    end
  end

  assign ready_o   = (state_q == S_IDLE);
  assign rd_en_o   = (state_q == S_RUN);
  assign rd_idx_o  = rd_idx_q;
  assign wr_en_o   = wr_en_q;
  assign wr_idx_o  = wr_idx_q;
  assign wr_data_o = wr_data_q;
  assign done_o    = (state_q == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_vshift_seq.sv
// ============================================================================
// Module   : tb_vshift_seq
// Function : Self-checking bench for vshift_seq with a behavioural reference.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vshift_seq;
  localparam int DW  = 32;
  localparam int MVL = 8;
  localparam int VLW = 4;

  logic           clk = 1'b0;
  logic           rst_i, start_i, ready_o, scalar_sel_i, kill_i;
  logic [1:0]     op_i;
  logic [VLW-1:0] vl_i, rd_idx_o, wr_idx_o;
  logic [DW-1:0]  scalar_i, rd_a_i, rd_b_i, sh_a_o, sh_amt_o, sh_result_i, wr_data_o;
  logic           rd_en_o, sh_dir_o, sh_tc_o, wr_en_o, done_o;
`ifdef VSHIFT_MASK_EN
  logic [MVL-1:0] mask_i;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0]  mem_a [16];
  logic [DW-1:0]  mem_b [16];
  logic [DW-1:0]  last_wdata;
  logic [VLW-1:0] last_widx, last_ridx;

  always #5 clk = ~clk;

  vshift_seq #(.DATA_WIDTH(DW), .MAX_VL(MVL), .VL_W(VLW)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .ready_o(ready_o),
    .op_i(op_i), .vl_i(vl_i), .scalar_sel_i(scalar_sel_i), .scalar_i(scalar_i),
    .kill_i(kill_i), .rd_en_o(rd_en_o), .rd_idx_o(rd_idx_o),
    .rd_a_i(rd_a_i), .rd_b_i(rd_b_i), .sh_a_o(sh_a_o), .sh_amt_o(sh_amt_o),
    .sh_dir_o(sh_dir_o), .sh_tc_o(sh_tc_o), .sh_result_i(sh_result_i),
    .wr_en_o(wr_en_o), .wr_idx_o(wr_idx_o), .wr_data_o(wr_data_o),
`ifdef VSHIFT_MASK_EN
    .mask_i(mask_i),
`endif
    .done_o(done_o)
  );

  // Operand memory and the shared shifter the sequencer drives.
  always_comb begin
    rd_a_i = mem_a[rd_idx_o];
    rd_b_i = mem_b[rd_idx_o];
  end

  logic [DW-1:0] ramt;
  always_comb begin
    ramt        = '0;
    sh_result_i = sh_a_o << sh_amt_o;
    if (sh_dir_o && $signed(sh_amt_o) < 0) begin
      ramt        = -sh_amt_o;
      sh_result_i = sh_tc_o ? DW'($signed(sh_a_o) >>> ramt) : (sh_a_o >> ramt);
    end
  end

  function automatic logic [DW-1:0] ref_shift(input logic [1:0] op, input logic [DW-1:0] a,
                                              input logic [DW-1:0] amt);
    int m;
    m = int'(amt % DW);
    case (op)
      2'b01:   return a >> m;
      2'b10:   return DW'($signed(a) >>> m);
      default: return a << m;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " ready"},   DW'(ready_o),   1);
    chk({tag, " rd_en"},   DW'(rd_en_o),   0);
    chk({tag, " wr_en"},   DW'(wr_en_o),   0);
    chk({tag, " done"},    DW'(done_o),    0);
    chk({tag, " rd_idx"},  DW'(rd_idx_o),  0);
    chk({tag, " wr_idx"},  DW'(wr_idx_o),  0);
    chk({tag, " wr_data"}, wr_data_o,      0);
  endtask

  // Issues one instruction in the current (IDLE) cycle and checks every
  // following cycle up to and including the one where ready returns.
  task automatic run_instr(input logic [1:0] op, input int vl, input logic sel,
                           input logic [DW-1:0] scal, input logic [MVL-1:0] msk_in, input int kc);
    int n, dcyc, rcyc, k;
    logic [MVL-1:0] msk;
    logic [DW-1:0]  expd [MVL];
    bit live, e_rd, e_wr;
    msk = msk_in;
`ifndef VSHIFT_MASK_EN
    msk = '1;
`endif
    n = (vl > MVL) ? MVL : vl;
    for (int i = 0; i < MVL; i++)
      expd[i] = ref_shift(op, mem_a[i], sel ? scal : mem_b[i]);
    dcyc = (n > 0) ? n + 2 : 1;
    rcyc = dcyc + 1;
    if (kc >= 1 && kc + 1 < rcyc) rcyc = kc + 1;

    chk("ready_at_start", DW'(ready_o), 1);
    start_i = 1'b1; kill_i = 1'b0; op_i = op; vl_i = VLW'(vl);
    scalar_sel_i = sel; scalar_i = scal;
`ifdef VSHIFT_MASK_EN
    mask_i = msk_in;
`endif
    for (int t = 1; t <= rcyc; t++) begin
      @(negedge clk);
      kill_i       = (t == kc) && (t < rcyc);
      start_i      = (t < rcyc) ? 1'($urandom_range(0, 1)) : 1'b0;
      op_i         = 2'($urandom);
      vl_i         = VLW'($urandom);
      scalar_sel_i = 1'($urandom);
      scalar_i     = $urandom;
`ifdef VSHIFT_MASK_EN
      mask_i       = MVL'($urandom);
`endif
      live = (kc < 1) || (t <= kc);
      e_rd = live && (t <= n);
      k    = t - 3;
      e_wr = live && (k >= 0) && (k < n) && msk[k[2:0]];

      chk($sformatf("rd_en c%0d", t), DW'(rd_en_o), DW'(e_rd));
      if (e_rd) last_ridx = VLW'(t - 1);
      chk($sformatf("rd_idx c%0d", t), DW'(rd_idx_o), DW'(last_ridx));
      chk($sformatf("wr_en c%0d", t), DW'(wr_en_o), DW'(e_wr));
      if (e_wr) begin
        last_widx  = VLW'(k);
        last_wdata = expd[k];
      end
      chk($sformatf("wr_idx c%0d", t), DW'(wr_idx_o), DW'(last_widx));
      chk($sformatf("wr_data c%0d", t), wr_data_o, last_wdata);
      chk($sformatf("done c%0d", t), DW'(done_o), DW'(live && t == dcyc));
      chk($sformatf("ready c%0d", t), DW'(ready_o), DW'(t == rcyc));
    end
    kill_i = 1'b0;
  endtask

  task automatic fill_mem(input bit rnd);
    for (int i = 0; i < 16; i++) begin
      mem_a[i] = rnd ? $urandom : DW'(i + 1);
      mem_b[i] = rnd ? $urandom : DW'(i);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int vl, n, kc;
    rst_i = 1'b1; start_i = 1'b0; kill_i = 1'b0; op_i = '0; vl_i = '0;
    scalar_sel_i = 1'b0; scalar_i = '0;
`ifdef VSHIFT_MASK_EN
    mask_i = '0;
`endif
    last_wdata = '0; last_widx = '0; last_ridx = '0;
    fill_mem(1'b0);
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst_i = 1'b0;

    // Scalar SLL, elements 1..4 shifted by 3, issued on the first edge after reset.
    run_instr(2'b00, 4, 1'b1, 32'd3, '1, 0);
    chk("sll_last_data", wr_data_o, 32'd32);

    // Per-element SRA/SRL with an amount whose high bits must be ignored.
    mem_a[0] = 32'h8000_0000; mem_b[0] = 32'h24;
    run_instr(2'b10, 1, 1'b0, 32'd0, '1, 0);
    chk("sra_masked_amt", wr_data_o, 32'hF800_0000);
    run_instr(2'b01, 1, 1'b0, 32'd0, '1, 0);
    chk("srl_masked_amt", wr_data_o, 32'h0800_0000);

    // Zero-length instruction, then over-length clamped to MAX_VL.
    run_instr(2'b00, 0, 1'b1, 32'd5, '1, 0);
    fill_mem(1'b1);
    run_instr(2'b11, 12, 1'b0, 32'd0, '1, 0);
    chk("clamp_last_idx", DW'(wr_idx_o), 32'd7);

    // Kill at cycle 4 of an 8-element run, start accepted at cycle 5.
    run_instr(2'b10, 8, 1'b0, 32'd0, '1, 4);
    run_instr(2'b01, 3, 1'b1, 32'd7, '1, 4);   // kill in DRAIN
    run_instr(2'b00, 3, 1'b0, 32'd0, '1, 5);   // kill in DONE

    // start together with kill in IDLE is ignored; kill alone in IDLE is harmless.
    start_i = 1'b1; kill_i = 1'b1; vl_i = 4'd3;
    @(negedge clk);
    start_i = 1'b0; kill_i = 1'b0;
    chk("start_kill_ready", DW'(ready_o), 1);
    chk("start_kill_rd_en", DW'(rd_en_o), 0);
    kill_i = 1'b1;
    @(negedge clk);
    kill_i = 1'b0;
    chk("idle_kill_ready", DW'(ready_o), 1);

`ifdef VSHIFT_MASK_EN
    run_instr(2'b00, 4, 1'b1, 32'd1, 8'b0000_0101, 0);
    run_instr(2'b01, 4, 1'b1, 32'd1, 8'b0000_0000, 0);
`endif

    // Reset in the middle of an instruction.
    start_i = 1'b1; vl_i = 4'd4; op_i = 2'b00; scalar_sel_i = 1'b1; scalar_i = 32'd1;
    @(negedge clk);
    start_i = 1'b0;
    @(negedge clk);
    rst_i = 1'b1;
    #1;
    chk_reset_vals("midrst");
    @(negedge clk);
    chk_reset_vals("midrst_c3");
    rst_i = 1'b0;
    last_wdata = '0; last_widx = '0; last_ridx = '0;
    run_instr(2'b10, 5, 1'b0, 32'd0, '1, 0);

    // Randomised instructions, some of them killed.
    for (int r = 0; r < 14; r++) begin
      fill_mem(1'b1);
      vl = $urandom_range(0, 15);
      n  = (vl > MVL) ? MVL : vl;
      kc = ($urandom_range(0, 3) == 0) ? $urandom_range(1, n + 2) : 0;
      run_instr(2'($urandom), vl, 1'($urandom), $urandom, MVL'($urandom), kc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
